id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- Decode-to-execute pipeline register of the Quinta RV32I core. Sits directly downstream of forwarding_unit.
- Selects each source operand from forwarded data or register-file data. Detects the hazards forwarding cannot cover and inserts bubbles while holding IF/ID.
- Squashes on taken branches and keeps stall/flush performance counters.

Parameters:
- CNT_W, 32, width of the stall and flush performance counters (saturating).

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- control_id  in  control_t  decoded control of the instruction currently in ID
- rs_1_id  in  5  source register 1 of the ID instruction
- rs_2_id  in  5  source register 2 of the ID instruction
- uses_rs_1  in  1  ID instruction reads rs_1
- uses_rs_2  in  1  ID instruction reads rs_2
- pc_id  in  32  PC of the ID instruction
- imm_id  in  32  decoded immediate
- reg_data_1  in  32  register-file read port 1
- reg_data_2  in  32  register-file read port 2
- fwd_data_1  in  32  forwarding_unit data_1
- fwd_data_1_valid  in  1  forwarding_unit data_1_valid
- fwd_data_2  in  32  forwarding_unit data_2
- fwd_data_2_valid  in  1  forwarding_unit data_2_valid
- control_ex_in  in  control_t  control currently in EX (this block's own output, fed back by top level)
- control_mem  in  control_t  control currently in MEM
- branch_taken  in  1  EX resolved a taken branch/jump this cycle
- stall_if_id  out  1  combinational; hold PC and IF/ID register this cycle
- control_ex  out  control_t  registered control for EX
- operand_1_ex  out  32  registered operand 1
- operand_2_ex  out  32  registered operand 2
- rs_1_ex  out  5  registered rs_1
- rs_2_ex  out  5  registered rs_2
- pc_ex  out  32  registered PC
- imm_ex  out  32  registered immediate
- stall_count  out  CNT_W  bubbles inserted by hazards
- flush_count  out  CNT_W  bubbles inserted by flushes

Behaviour:
- Operand select, per source n:
  - rs_n_id == 0 gives 0, regardless of forwarding inputs.
  - Otherwise fwd_data_n if fwd_data_n_valid, else reg_data_n.
- Hazard term, per source n. The term is true when uses_rs_n, rs_n_id != 0, and either condition below holds:
  - (a) control_ex_in.reg_write && control_ex_in.write_back_id == rs_n_id. EX results are not forwardable; any producer in EX stalls.
  - (b) control_mem.reg_write && control_mem.mem_read && control_mem.write_back_id == rs_n_id. Load data is unavailable in MEM.
- hazard = term1 | term2.
- stall_if_id = hazard && !branch_taken.
- Resulting bubble counts: ALU producer directly ahead gives 1 bubble. Load directly ahead gives 2 bubbles (a, then b). Load two ahead gives 1 bubble. Hazard clears naturally as the producer advances; no extra state is needed.
- Register update priority at each clock edge: rst > branch_taken > hazard > capture.
  - rst: all registered outputs 0, control_ex = '0 (bubble), both counters 0.
  - branch_taken: load bubble ('0 control, data fields 0); flush_count +1 (saturating). This applies even if hazard is set.
  - hazard (no flush): load bubble; stall_count +1 (saturating).
  - Otherwise: capture control_id, selected operands, rs_1/2, pc, imm.
- Bubble control has reg_write = 0, mem_read = 0, write_back_id = 0. Downstream treats it as a NOP.
- Counters saturate at all-ones and never wrap.
- Reset mid-stall: next cycle outputs bubble, and stall_if_id is recomputed from the (reset) EX/MEM control.
- Latency: one cycle from ID inputs to EX outputs.
- No combinational path from branch_taken to registered data; only stall_if_id depends on it combinationally.

Decomposition:
- common_pkg:
  - reuse control_t
  - add localparam control_t CONTROL_BUBBLE = '0
  - add function is_raw(control_t c, logic [4:0] rs)
- Sub-module hazard_detect, combinational: rs/uses/control_ex_in/control_mem/branch_taken in, hazard and stall_if_id out. The pipeline register and counters stay in id_ex_stage.

Test Plan:
- Straight line:
  - addi x1,x0,5, then independent addi x2,x0,7.
  - Each appears on control_ex one cycle after ID; stall_count stays 0.
- x0 guard:
  - rs_1_id=0 with fwd_data_1=32'hDEAD_BEEF, fwd_data_1_valid=1.
  - operand_1_ex=0; no stall even if control_ex_in.write_back_id=0 and reg_write=1.
- ALU-use:
  - add x3 in EX, ID reads x3.
  - stall_if_id=1 for exactly 1 cycle, one bubble, stall_count=1.
  - Next cycle fwd_data_1=alu_res_mem=0x12 is captured into operand_1_ex.
- Load-use:
  - lw x4 in EX, ID reads x4 on rs_2.
  - 2 stall cycles, stall_count=2; operand_2_ex equals mem_data_wb value 0xCAFE.
- Flush over stall:
  - branch_taken=1 while a load-use hazard is present.
  - stall_if_id=0, bubble loaded, flush_count+1, stall_count unchanged.
- Saturation/reset:
  - Preload stall_count near max (force or CNT_W=4), hold hazard 20 cycles: count sticks at 4'hF.
  - Assert rst mid-stall: all outputs 0 the next cycle.

Source files
------------

// File: rtl/common_pkg.sv
// Shared types for the Quinta RV32I pipeline.
//   control_t      : decoded control word carried down the pipe
//   CONTROL_BUBBLE : all-zero control, treated as a NOP downstream
//   is_raw()       : true when a stage's control writes a given (non-x0) register
package common_pkg;

  localparam int XLEN    = 32;
  localparam int REG_W   = 5;
  localparam int NUM_SRC = 2;

  typedef struct packed {
    logic             reg_write;
    logic             mem_read;
    logic             mem_write;
    logic             branch;
    logic             jump;
    logic             alu_src;
    logic [3:0]       alu_op;
    logic [REG_W-1:0] write_back_id;
  } control_t;

  localparam control_t CONTROL_BUBBLE = '0;

  // x0 is never a real producer, so a write to it cannot create a dependency.
  function automatic logic is_raw(control_t c, logic [REG_W-1:0] rs);
    return c.reg_write && (rs != '0) && (c.write_back_id == rs);
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational detection of the hazards forwarding cannot cover.
//   rs_1_id/rs_2_id, uses_rs_1/uses_rs_2 : sources of the ID instruction
//   control_ex_in, control_mem           : producers currently in EX / MEM
//   branch_taken                         : EX squashes this cycle
//   hazard                               : a source depends on an unforwardable result
//   stall_if_id                          : hold PC and IF/ID (suppressed by a flush)
module hazard_detect
  import common_pkg::*;
(
  input  control_t         control_ex_in,
  input  control_t         control_mem,
  input  logic [REG_W-1:0] rs_1_id,
  input  logic [REG_W-1:0] rs_2_id,
  input  logic             uses_rs_1,
  input  logic             uses_rs_2,
  input  logic             branch_taken,
  output logic             hazard,
  output logic             stall_if_id
);

  logic [NUM_SRC-1:0][REG_W-1:0] rs;
  logic [NUM_SRC-1:0]            uses;
  logic [NUM_SRC-1:0]            term;

  assign rs   = {rs_2_id, rs_1_id};
  assign uses = {uses_rs_2, uses_rs_1};

  // EX results never forward, so any EX producer stalls; a MEM producer
  // only stalls when it is a load whose data is still in flight.
  for (genvar n = 0; n < NUM_SRC; n++) begin : g_src
    assign term[n] = uses[n] && (rs[n] != '0) &&
                     (is_raw(control_ex_in, rs[n]) ||
                      (control_mem.mem_read && is_raw(control_mem, rs[n])));
  end

  assign hazard      = |term;
  // A taken branch squashes the dependent instruction anyway; stalling
  // would only delay the redirect.
  assign stall_if_id = hazard && !branch_taken;

  // Only a few control fields matter for hazards.
  logic unused_ctrl;
  assign unused_ctrl = ^{control_ex_in, control_mem};

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register of the Quinta RV32I core.
//   Inputs : decoded ID instruction, register-file and forwarding data,
//            EX/MEM control for hazard checks, branch_taken from EX.
//   Outputs: stall_if_id (combinational), registered EX control/operands/
//            rs/pc/imm, saturating stall and flush bubble counters.
// Priority at each edge: rst > branch_taken (flush bubble) > hazard
// (stall bubble) > capture. Latency ID -> EX is one cycle.
module id_ex_stage
  import common_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  control_t         control_id,
  input  logic [REG_W-1:0] rs_1_id,
  input  logic [REG_W-1:0] rs_2_id,
  input  logic             uses_rs_1,
  input  logic             uses_rs_2,
  input  logic [XLEN-1:0]  pc_id,
  input  logic [XLEN-1:0]  imm_id,
  input  logic [XLEN-1:0]  reg_data_1,
  input  logic [XLEN-1:0]  reg_data_2,
  input  logic [XLEN-1:0]  fwd_data_1,
  input  logic             fwd_data_1_valid,
  input  logic [XLEN-1:0]  fwd_data_2,
  input  logic             fwd_data_2_valid,
  input  control_t         control_ex_in,
  input  control_t         control_mem,
  input  logic             branch_taken,
  output logic             stall_if_id,
  output control_t         control_ex,
  output logic [XLEN-1:0]  operand_1_ex,
  output logic [XLEN-1:0]  operand_2_ex,
  output logic [REG_W-1:0] rs_1_ex,
  output logic [REG_W-1:0] rs_2_ex,
  output logic [XLEN-1:0]  pc_ex,
  output logic [XLEN-1:0]  imm_ex,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic hazard;

  hazard_detect u_hazard (
    .control_ex_in (control_ex_in),
    .control_mem   (control_mem),
    .rs_1_id       (rs_1_id),
    .rs_2_id       (rs_2_id),
    .uses_rs_1     (uses_rs_1),
    .uses_rs_2     (uses_rs_2),
    .branch_taken  (branch_taken),
    .hazard        (hazard),
    .stall_if_id   (stall_if_id)
  );

  // Operand select: x0 reads as zero no matter what forwarding claims.
  logic [NUM_SRC-1:0][REG_W-1:0] rs_id;
  logic [NUM_SRC-1:0][XLEN-1:0]  reg_data, fwd_data, operand;
  logic [NUM_SRC-1:0]            fwd_valid;

  assign rs_id     = {rs_2_id, rs_1_id};
  assign reg_data  = {reg_data_2, reg_data_1};
  assign fwd_data  = {fwd_data_2, fwd_data_1};
  assign fwd_valid = {fwd_data_2_valid, fwd_data_1_valid};

  for (genvar n = 0; n < NUM_SRC; n++) begin : g_opnd
    assign operand[n] = (rs_id[n] == '0) ? '0 :
                        fwd_valid[n]     ? fwd_data[n] : reg_data[n];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      control_ex   <= CONTROL_BUBBLE;
      operand_1_ex <= '0;
      operand_2_ex <= '0;
      rs_1_ex      <= '0;
      rs_2_ex      <= '0;
      pc_ex        <= '0;
      imm_ex       <= '0;
      stall_count  <= '0;
      flush_count  <= '0;
    end else if (branch_taken || hazard) begin
      // Both cases load the same bubble; only the counter differs.
      control_ex   <= CONTROL_BUBBLE;
      operand_1_ex <= '0;
      operand_2_ex <= '0;
      rs_1_ex      <= '0;
      rs_2_ex      <= '0;
      pc_ex        <= '0;
      imm_ex       <= '0;
      if (branch_taken) begin
        if (flush_count != '1) flush_count <= flush_count + CNT_ONE;
      end else begin
        if (stall_count != '1) stall_count <= stall_count + CNT_ONE;
      end
    end else begin
      control_ex   <= control_id;
      operand_1_ex <= operand[0];
      operand_2_ex <= operand[1];
      rs_1_ex      <= rs_1_id;
      rs_2_ex      <= rs_2_id;
      pc_ex        <= pc_id;
      imm_ex       <= imm_id;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;
  import common_pkg::*;

  localparam int CNT_W = 4;
  localparam int CW    = $bits(control_t);
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  control_t         control_id, control_ex_in, control_mem, control_ex;
  logic [4:0]       rs_1_id, rs_2_id, rs_1_ex, rs_2_ex;
  logic             uses_rs_1, uses_rs_2, branch_taken, stall_if_id;
  logic [31:0]      pc_id, imm_id, reg_data_1, reg_data_2, fwd_data_1, fwd_data_2;
  logic             fwd_data_1_valid, fwd_data_2_valid;
  logic [31:0]      operand_1_ex, operand_2_ex, pc_ex, imm_ex;
  logic [CNT_W-1:0] stall_count, flush_count;

  id_ex_stage #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .control_id(control_id), .rs_1_id(rs_1_id), .rs_2_id(rs_2_id),
    .uses_rs_1(uses_rs_1), .uses_rs_2(uses_rs_2), .pc_id(pc_id), .imm_id(imm_id),
    .reg_data_1(reg_data_1), .reg_data_2(reg_data_2),
    .fwd_data_1(fwd_data_1), .fwd_data_1_valid(fwd_data_1_valid),
    .fwd_data_2(fwd_data_2), .fwd_data_2_valid(fwd_data_2_valid),
    .control_ex_in(control_ex_in), .control_mem(control_mem), .branch_taken(branch_taken),
    .stall_if_id(stall_if_id), .control_ex(control_ex),
    .operand_1_ex(operand_1_ex), .operand_2_ex(operand_2_ex),
    .rs_1_ex(rs_1_ex), .rs_2_ex(rs_2_ex), .pc_ex(pc_ex), .imm_ex(imm_ex),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  int n_chk = 0, n_fail = 0;
  bit chk_en = 1'b0;
  bit fb = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  control_t    m_ctrl, m_mem;   // what EX should hold, and what MEM holds behind it
  logic [31:0] m_op1, m_op2, m_pc, m_imm;
  logic [4:0]  m_rs1, m_rs2;
  int          m_sc, m_fc;

  function automatic bit depends(input logic u, input logic [4:0] rs);
    if (!u || rs == 5'd0) return 1'b0;
    if (control_ex_in.reg_write && control_ex_in.write_back_id == rs) return 1'b1;
    if (control_mem.reg_write && control_mem.mem_read && control_mem.write_back_id == rs) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_hazard();
    return depends(uses_rs_1, rs_1_id) || depends(uses_rs_2, rs_2_id);
  endfunction

  function automatic logic [31:0] pick(input logic [4:0] rs, input logic v,
                                       input logic [31:0] f, input logic [31:0] r);
    if (rs == 5'd0) return 32'd0;
    return v ? f : r;
  endfunction

  always @(posedge clk) begin
    m_mem <= rst ? control_t'(0) : m_ctrl;
    if (rst || branch_taken || m_hazard()) begin
      m_ctrl <= '0; m_op1 <= 0; m_op2 <= 0; m_rs1 <= 0; m_rs2 <= 0; m_pc <= 0; m_imm <= 0;
      if (rst) begin
        m_sc <= 0; m_fc <= 0;
      end else if (branch_taken) begin
        m_fc <= (m_fc < CMAX) ? m_fc + 1 : m_fc;
      end else begin
        m_sc <= (m_sc < CMAX) ? m_sc + 1 : m_sc;
      end
    end else begin
      m_ctrl <= control_id;
      m_op1  <= pick(rs_1_id, fwd_data_1_valid, fwd_data_1, reg_data_1);
      m_op2  <= pick(rs_2_id, fwd_data_2_valid, fwd_data_2, reg_data_2);
      m_rs1  <= rs_1_id; m_rs2 <= rs_2_id; m_pc <= pc_id; m_imm <= imm_id;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("control_ex", 32'(control_ex), 32'(m_ctrl));
      chk("operand_1_ex", operand_1_ex, m_op1);
      chk("operand_2_ex", operand_2_ex, m_op2);
      chk("rs_1_ex", 32'(rs_1_ex), 32'(m_rs1));
      chk("rs_2_ex", 32'(rs_2_ex), 32'(m_rs2));
      chk("pc_ex", pc_ex, m_pc);
      chk("imm_ex", imm_ex, m_imm);
      chk("stall_count", 32'(stall_count), m_sc);
      chk("flush_count", 32'(flush_count), m_fc);
      chk("stall_if_id", 32'(stall_if_id), 32'(m_hazard() && !branch_taken));
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic control_t mk(input logic rw, input logic mr, input logic [4:0] wb);
    control_t c;
    c = '0;
    c.reg_write = rw; c.mem_read = mr; c.alu_src = 1'b1; c.write_back_id = wb;
    return c;
  endfunction

  function automatic control_t rand_ctrl();
    control_t c;
    c = control_t'(CW'($urandom));
    c.write_back_id = 5'($urandom_range(0, 7));
    return c;
  endfunction

  task automatic set_id(input control_t c, input logic [4:0] r1, input logic [4:0] r2,
                        input logic u1, input logic u2, input logic [31:0] pc, input logic [31:0] imm);
    control_id = c; rs_1_id = r1; rs_2_id = r2; uses_rs_1 = u1; uses_rs_2 = u2;
    pc_id = pc; imm_id = imm;
    reg_data_1 = 32'h1000_0000 | pc; reg_data_2 = 32'h2000_0000 | pc;
    fwd_data_1 = 32'h0; fwd_data_1_valid = 1'b0; fwd_data_2 = 32'h0; fwd_data_2_valid = 1'b0;
  endtask

  task automatic sync_fb();
    control_ex_in = m_ctrl; control_mem = m_mem;
  endtask

  task automatic tick();
    @(posedge clk); #1;
    if (fb) sync_fb();
  endtask

  task automatic mid();
    @(negedge clk); #1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    rst = 1'b1; branch_taken = 1'b0;
    control_ex_in = '0; control_mem = '0;
    set_id('0, 0, 0, 0, 0, 0, 0);
    tick(); chk_en = 1'b1;
    tick();
    mid();
    chk("reset control_ex", 32'(control_ex), 32'h0);
    chk("reset stall_count", 32'(stall_count), 32'h0);
    chk("reset operand_1_ex", operand_1_ex, 32'h0);
    rst = 1'b0;

    // straight line: addi x1,x0,5 ; addi x2,x0,7
    set_id(mk(1, 0, 1), 0, 0, 1, 0, 32'h0, 32'd5);
    tick();
    set_id(mk(1, 0, 2), 0, 0, 1, 0, 32'h4, 32'd7);
    mid();
    chk("line1 wb_id", 32'(control_ex.write_back_id), 32'd1);
    chk("line1 imm", imm_ex, 32'd5);
    tick(); mid();
    chk("line2 wb_id", 32'(control_ex.write_back_id), 32'd2);
    chk("line2 imm", imm_ex, 32'd7);
    chk("line stall_count", 32'(stall_count), 32'd0);

    // x0 guard: forwarding claims DEADBEEF for x0, EX claims to write x0
    set_id(mk(1, 0, 8), 0, 0, 1, 0, 32'h8, 32'd0);
    fwd_data_1 = 32'hDEAD_BEEF; fwd_data_1_valid = 1'b1;
    fb = 1'b0; control_ex_in = mk(1, 0, 0); control_mem = '0;
    mid();
    chk("x0 stall_if_id", 32'(stall_if_id), 32'd0);
    tick(); mid();
    chk("x0 operand_1_ex", operand_1_ex, 32'h0);
    fb = 1'b1; sync_fb();

    // ALU-use: add x3 then consumer of x3 on rs_1
    set_id(mk(1, 0, 3), 1, 2, 1, 1, 32'hC, 32'd0);
    tick();
    set_id(mk(1, 0, 5), 3, 0, 1, 0, 32'h10, 32'd0);
    mid();
    chk("alu-use stall c1", 32'(stall_if_id), 32'd1);
    tick();
    fwd_data_1 = 32'h12; fwd_data_1_valid = 1'b1;
    mid();
    chk("alu-use stall c2", 32'(stall_if_id), 32'd0);
    chk("alu-use stall_count", 32'(stall_count), 32'd1);
    tick(); mid();
    chk("alu-use operand_1_ex", operand_1_ex, 32'h12);

    // load-use: lw x4 then consumer of x4 on rs_2
    set_id(mk(1, 1, 4), 0, 0, 0, 0, 32'h14, 32'd0);
    tick();
    set_id(mk(1, 0, 9), 0, 4, 0, 1, 32'h18, 32'd0);
    mid();
    chk("load-use stall c1", 32'(stall_if_id), 32'd1);
    tick(); mid();
    chk("load-use stall c2", 32'(stall_if_id), 32'd1);
    tick();
    fwd_data_2 = 32'hCAFE; fwd_data_2_valid = 1'b1;
    mid();
    chk("load-use stall c3", 32'(stall_if_id), 32'd0);
    chk("load-use stall_count", 32'(stall_count), 32'd3);
    tick(); mid();
    chk("load-use operand_2_ex", operand_2_ex, 32'hCAFE);

    // flush over a load-use stall
    set_id(mk(1, 1, 6), 0, 0, 0, 0, 32'h1C, 32'd0);
    tick();
    set_id(mk(1, 0, 10), 6, 0, 1, 0, 32'h20, 32'd0);
    branch_taken = 1'b1;
    mid();
    chk("flush stall_if_id", 32'(stall_if_id), 32'd0);
    tick();
    branch_taken = 1'b0;
    mid();
    chk("flush control_ex", 32'(control_ex), 32'h0);
    chk("flush flush_count", 32'(flush_count), 32'd1);
    chk("flush stall_count", 32'(stall_count), 32'd3);

    // saturation: hold an EX hazard for 20 cycles
    fb = 1'b0; control_ex_in = mk(1, 0, 7); control_mem = '0;
    set_id(mk(1, 0, 11), 7, 0, 1, 0, 32'h24, 32'd0);
    repeat (20) tick();
    mid();
    chk("sat stall_count", 32'(stall_count), 32'hF);
    chk("sat stall_if_id", 32'(stall_if_id), 32'd1);

    // reset mid-stall; EX/MEM control follows the reset pipe
    rst = 1'b1; fb = 1'b1;
    tick(); mid();
    chk("rst control_ex", 32'(control_ex), 32'h0);
    chk("rst stall_count", 32'(stall_count), 32'h0);
    chk("rst flush_count", 32'(flush_count), 32'h0);
    chk("rst stall_if_id", 32'(stall_if_id), 32'd0);
    rst = 1'b0;

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      rst          = ($urandom_range(0, 99) == 0);
      branch_taken = ($urandom_range(0, 9) == 0);
      control_id   = rand_ctrl();
      rs_1_id      = 5'($urandom_range(0, 7));
      rs_2_id      = 5'($urandom_range(0, 7));
      uses_rs_1    = 1'($urandom);
      uses_rs_2    = 1'($urandom);
      pc_id        = $urandom; imm_id = $urandom;
      reg_data_1   = $urandom; reg_data_2 = $urandom;
      fwd_data_1   = $urandom; fwd_data_2 = $urandom;
      fwd_data_1_valid = 1'($urandom); fwd_data_2_valid = 1'($urandom);
      if ($urandom_range(0, 1) == 0) sync_fb();
      else begin
        control_ex_in = rand_ctrl();
        control_mem   = rand_ctrl();
      end
    end
    mid();
    chk_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
